// File: rtl/branch_resolve_bht.sv
// Branch resolver with a direct-mapped table of 2-bit counters for fetch prediction.
// Define BRU_PERF_CNT_EN to add saturating branch/mispredict performance counters.
module branch_resolve_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic [2:0]       res_funct3,
    input  logic             res_branch,
    input  logic             res_jump,
    input  logic [XLEN-1:0]  res_rs1,
    input  logic [XLEN-1:0]  res_rs2,
    input  logic             res_pred,
    output logic             pcsrc,
    output logic             illegal_br,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] res_idx;
    logic [1:0]       cur;
    logic             cond;
    logic             update;
    logic             miss;

    // Word-aligned PCs: the two low bits never select an entry.
    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign res_idx   = res_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                              res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

    always_comb begin
        cond = 1'b0;
        case (res_funct3)
            3'b000:  cond = (res_rs1 == res_rs2);
            3'b001:  cond = (res_rs1 != res_rs2);
            3'b100:  cond = ($signed(res_rs1) <  $signed(res_rs2));
            3'b101:  cond = ($signed(res_rs1) >= $signed(res_rs2));
            3'b110:  cond = (res_rs1 <  res_rs2);
            3'b111:  cond = (res_rs1 >= res_rs2);
            default: cond = 1'b0;
        endcase
    end

    assign illegal_br = res_valid & res_branch & (res_funct3[2:1] == 2'b01);
    assign pcsrc      = res_valid & ((res_branch & cond) | res_jump);
    // Jumps are redirected at decode, so they neither train nor mispredict.
    assign update     = res_valid & res_branch & ~res_jump & ~illegal_br;
    assign miss       = update & (cond != res_pred);

    assign pred_taken = bht[fetch_idx][1];
    assign cur        = bht[res_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
            mispredict <= 1'b0;
        end else begin
            mispredict <= miss;
            if (update) begin
                if (cond && cur != 2'b11)       bht[res_idx] <= cur + 2'd1;
                else if (!cond && cur != 2'b00) bht[res_idx] <= cur - 2'd1;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (update && br_count != '1) br_count <= br_count + CNT_W'(1);
            if (miss && mp_count != '1)   mp_count <= mp_count + CNT_W'(1);
        end
    end
`else
    assign br_count = '0;
    assign mp_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: compares, table training, mispredict and reset.
module tb_branch_resolve_bht;
    localparam int CW = 4;
`ifdef BRU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   fetch_pc;
    logic          pred_taken;
    logic          res_valid;
    logic [31:0]   res_pc;
    logic [2:0]    res_funct3;
    logic          res_branch;
    logic          res_jump;
    logic [31:0]   res_rs1;
    logic [31:0]   res_rs2;
    logic          res_pred;
    logic          pcsrc;
    logic          illegal_br;
    logic          mispredict;
    logic [CW-1:0] br_count;
    logic [CW-1:0] mp_count;

    int total = 0;
    int bad   = 0;

    branch_resolve_bht #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
        .res_branch(res_branch), .res_jump(res_jump), .res_rs1(res_rs1),
        .res_rs2(res_rs2), .res_pred(res_pred), .pcsrc(pcsrc),
        .illegal_br(illegal_br), .mispredict(mispredict),
        .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        br;
        logic        jp;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        pc;
        logic        il;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        res_valid = 1'b0; res_branch = 1'b0; res_jump = 1'b0; res_funct3 = 3'b000;
        res_pc = '0; res_rs1 = '0; res_rs2 = '0; res_pred = 1'b0;
    endtask

    task automatic br(input logic [31:0] pc, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic pd);
        res_valid = 1'b1; res_branch = 1'b1; res_jump = 1'b0; res_funct3 = f3;
        res_pc = pc; res_rs1 = a; res_rs2 = b; res_pred = pd;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'h1,         1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b101, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b000, 32'h3,         32'h4,         1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h3,         32'h4,         1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b101, 32'h5,         32'h5,         1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b110, 32'h1,         32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h5,         32'h5,         1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 3'b011, 32'h5,         32'h6,         1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h5,         32'h5,         1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h5,         32'h5,         1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h5,         32'h6,         1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 3'b111, 32'h5,         32'h5,         1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 3'b000, 32'h5,         32'h5,         1'b1, 1'b0};

        rst = 1'b1;
        idle();
        fetch_pc = 32'h100;
        #2;
        chk("rst_pred", pred_taken, 0);
        chk("rst_mp", mispredict, 0);
        chk("rst_brc", br_count, 0);
        chk("rst_mpc", mp_count, 0);

        // Combinational decode held under reset so the table cannot train.
        for (int i = 0; i < 16; i++) begin
            res_valid = vecs[i].v; res_branch = vecs[i].br; res_jump = vecs[i].jp;
            res_funct3 = vecs[i].f3; res_rs1 = vecs[i].a; res_rs2 = vecs[i].b;
            #1;
            chk($sformatf("pcsrc_v%0d", i), pcsrc, vecs[i].pc);
            chk($sformatf("illegal_v%0d", i), illegal_br, vecs[i].il);
        end
        chk("rst_hold_pred", pred_taken, 0);
        idle();
        tick();
        rst = 1'b0;

        // First taken beq at 0x100: 01 -> 10, mispredict next cycle.
        br(32'h100, 3'b000, 32'd5, 32'd5, 1'b0);
        #1;
        chk("beq_pcsrc", pcsrc, 1);
        chk("beq_pred_old", pred_taken, 0);
        tick();
        idle();
        chk("beq_mp", mispredict, 1);
        chk("beq_pred_new", pred_taken, 1);
        tick();
        chk("beq_mp_clear", mispredict, 0);

        // Saturation at 0x200 (same entry as 0x100, so start clean).
        do_reset();
        fetch_pc = 32'h200;
        br(32'h200, 3'b000, 32'd5, 32'd5, 1'b0);
        tick();
        chk("sat_mp0", mispredict, 1);
        chk("sat_pred0", pred_taken, 1);
        for (int k = 1; k < 4; k++) begin
            br(32'h200, 3'b000, 32'd5, 32'd5, 1'b1);
            tick();
            chk($sformatf("sat_mp%0d", k), mispredict, 0);
            chk($sformatf("sat_pred%0d", k), pred_taken, 1);
        end
        br(32'h200, 3'b000, 32'd5, 32'd6, 1'b1);
        tick();
        chk("nt1_mp", mispredict, 1);
        chk("nt1_pred", pred_taken, 1);
        tick();
        chk("nt2_mp_b2b", mispredict, 1);
        chk("nt2_pred", pred_taken, 0);
        tick();
        chk("nt3_mp_b2b", mispredict, 1);
        chk("nt3_pred", pred_taken, 0);
        br(32'h200, 3'b000, 32'd5, 32'd6, 1'b0);
        tick();
        chk("floor_mp", mispredict, 0);
        br(32'h200, 3'b000, 32'd5, 32'd5, 1'b0);
        tick();
        chk("floor_up_mp", mispredict, 1);
        chk("floor_up_pred", pred_taken, 0);

        // Jump with funct3 010: taken, not illegal, table untouched (entry stays 01).
        res_valid = 1'b1; res_branch = 1'b0; res_jump = 1'b1; res_funct3 = 3'b010;
        res_pc = 32'h200; res_rs1 = 32'd5; res_rs2 = 32'd6; res_pred = 1'b0;
        #1;
        chk("jmp_pcsrc", pcsrc, 1);
        chk("jmp_illegal", illegal_br, 0);
        tick();
        chk("jmp_mp", mispredict, 0);
        tick();
        chk("jmp_mp2", mispredict, 0);
        chk("jmp_pred", pred_taken, 0);
        br(32'h200, 3'b000, 32'd5, 32'd5, 1'b1);
        tick();
        chk("post_jmp_mp", mispredict, 0);
        chk("post_jmp_pred", pred_taken, 1);
        br(32'h200, 3'b000, 32'd5, 32'd6, 1'b1);
        tick();
        chk("post_jmp_nt_pred", pred_taken, 0);

        // Illegal funct3 011: no decision, no training, no mispredict.
        br(32'h200, 3'b011, 32'd5, 32'd5, 1'b1);
        #1;
        chk("ill_pcsrc", pcsrc, 0);
        chk("ill_flag", illegal_br, 1);
        tick();
        chk("ill_mp", mispredict, 0);
        br(32'h200, 3'b000, 32'd5, 32'd5, 1'b0);
        tick();
        chk("post_ill_mp", mispredict, 1);
        chk("post_ill_pred", pred_taken, 1);

        // Read-during-write at 0x300 (entry at 10 -> 01).
        fetch_pc = 32'h300;
        br(32'h300, 3'b000, 32'd5, 32'd6, 1'b1);
        #1;
        chk("rdw_old", pred_taken, 1);
        tick();
        chk("rdw_new", pred_taken, 0);
        chk("rdw_mp", mispredict, 1);

        // 0x400 aliases 0x300; 0x304 is a different entry.
        idle();
        fetch_pc = 32'h400;
        #1;
        chk("alias_rd", pred_taken, 0);
        br(32'h400, 3'b000, 32'd7, 32'd7, 1'b0);
        tick();
        idle();
        fetch_pc = 32'h300;
        #1;
        chk("alias_shared", pred_taken, 1);
        fetch_pc = 32'h304;
        #1;
        chk("alias_other", pred_taken, 0);

        // Performance counters: 20 mispredicting not-taken branches.
        do_reset();
        fetch_pc = 32'h100;
        for (int k = 0; k < 3; k++) begin
            br(32'h100, 3'b000, 32'd1, 32'd2, 1'b1);
            tick();
        end
        chk("perf_br3", br_count, PERF ? 3 : 0);
        chk("perf_mp3", mp_count, PERF ? 3 : 0);
        for (int k = 3; k < 20; k++) begin
            br(32'h100, 3'b000, 32'd1, 32'd2, 1'b1);
            tick();
        end
        chk("perf_br_sat", br_count, PERF ? 15 : 0);
        chk("perf_mp_sat", mp_count, PERF ? 15 : 0);
        chk("perf_mp_pulse", mispredict, 1);

        // Asynchronous reset with a training request pending.
        br(32'h100, 3'b000, 32'd5, 32'd5, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_mp", mispredict, 0);
        chk("arst_brc", br_count, 0);
        chk("arst_mpc", mp_count, 0);
        chk("arst_pred", pred_taken, 0);
        chk("arst_pcsrc", pcsrc, 1);
        fetch_pc = 32'h104;
        #1;
        chk("arst_pred2", pred_taken, 0);
        tick();
        rst = 1'b0;
        idle();
        fetch_pc = 32'h100;
        #1;
        chk("arst_discard", pred_taken, 0);
        chk("arst_mp_after", mispredict, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Parametrised successor to the single-cycle PC-source generator.
- Resolves all six RV32/RV64 conditional branches and jumps with correct full-width signed/unsigned compares.
- Adds a direct-mapped branch history table (BHT) of 2-bit saturating counters for fetch-stage prediction.
- Produces a registered mispredict/redirect pulse for pipelined cores; the combinational pcsrc is kept for single-cycle use.

Parameters:
- XLEN, 32, operand and PC width (32 or 64).
- BHT_ENTRIES, 64, number of counters; power of two, at least 2.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- fetch_pc  in  XLEN  PC looked up for prediction.
- pred_taken  out  1  prediction for fetch_pc.
- res_valid  in  1  a resolve request is present this cycle.
- res_pc  in  XLEN  PC of the resolving instruction.
- res_funct3  in  3  branch funct3.
- res_branch  in  1  instruction is a conditional branch.
- res_jump  in  1  instruction is JAL/JALR.
- res_rs1  in  XLEN  operand A.
- res_rs2  in  XLEN  operand B.
- res_pred  in  1  prediction carried from fetch.
- pcsrc  out  1  combinational taken decision.
- illegal_br  out  1  combinational; res_valid & res_branch with funct3 010 or 011.
- mispredict  out  1  registered one-cycle pulse.
- br_count  out  CNT_W  resolved conditional branches (optional feature only).
- mp_count  out  CNT_W  mispredicts (optional feature only).

Behaviour:
- Index: idx = pc[log2(BHT_ENTRIES)+1 : 2]; bits [1:0] are ignored.
- Condition, computed over the full XLEN width:
  - 000 beq: rs1 == rs2.
  - 001 bne: rs1 != rs2.
  - 100 blt: signed rs1 < rs2.
  - 101 bge: signed rs1 >= rs2.
  - 110 bltu: unsigned rs1 < rs2.
  - 111 bgeu: unsigned rs1 >= rs2.
  - 010, 011: condition 0.
- pcsrc = res_valid & ((res_branch & cond) | res_jump). It is 0 when res_valid is 0. A jump wins over any funct3.
- pred_taken = bit 1 of counter[idx(fetch_pc)]. Purely combinational read of the registered table.
- Update happens when res_valid & res_branch & ~res_jump & ~illegal_br:
  - counter[idx(res_pc)] saturating-increments if cond is 1, else saturating-decrements.
  - Written at the next rising edge.
  - 11 stays 11 on taken; 00 stays 00 on not-taken.
- Jumps and illegal funct3 never update the table.
- Read-during-write to the same index: pred_taken shows the old value in the update cycle and the new value from the next cycle.
- mispredict: registered. Asserted in cycle N+1 when, in cycle N, the update condition held and cond != res_pred.
  - Jumps never cause mispredict (they are redirected at decode).
  - Back-to-back resolves give back-to-back pulses.
- Reset (asynchronous, immediate):
  - every counter = 01 (weakly not-taken), so pred_taken = 0;
  - mispredict = 0;
  - counters = 0.
  - Reset asserted mid-update discards the update.
- Combinational outputs follow their inputs during reset; no output is X after reset.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - br_count increments on each table update;
  - mp_count increments in the same cycle as the update that will produce mispredict;
  - both saturate at all-ones and reset to 0.
- Undefined: br_count and mp_count are tied to 0 and no counter flops exist. The ports remain so the interface is unchanged.

Test Plan:
- Reset, then fetch_pc=0x100 -> pred_taken=0. res_valid=1, branch, funct3=000, rs1=rs2=5, res_pred=0 -> pcsrc=1; next cycle mispredict=1 and pred_taken for 0x100 becomes 1 (counter 10).
- blt with rs1=0xFFFFFFFF, rs2=1 -> pcsrc=1. bltu with the same operands -> pcsrc=0. bgeu with rs1=0x80000000, rs2=0x7FFFFFFF -> pcsrc=1 (checks bit 31).
- Resolve taken at 0x200 four times with res_pred=1 after the first -> counter saturates at 11, mispredict only after the first. One not-taken -> counter 10, pred_taken still 1, mispredict=1.
- Jump with funct3=010 and branch=0 -> pcsrc=1, illegal_br=0, no table change, no mispredict. Branch with funct3=011 -> pcsrc=0, illegal_br=1, no update.
- Update at 0x300 with fetch_pc=0x300 in the same cycle -> old prediction that cycle, new prediction the next cycle. Aliasing check: 0x300 and 0x400 (BHT_ENTRIES=64) share an entry.
- With BRU_PERF_CNT_EN, CNT_W=4: 20 mispredicting branches -> br_count=mp_count=15 (saturated). Assert rst mid-run -> all outputs clear immediately and pred_taken=0 everywhere.
